// File: rtl/iomem_wb_bridge_if.sv
// Bundle of the iomem request/response signals, the Wishbone master
// signals and the error status of iomem_wb_bridge.
// The master modport is the bridge's view; slave is the environment's view.
interface iomem_wb_bridge_if #(
  parameter int unsigned NUM_SLAVES = 2
);
  logic                       iomem_valid;
  logic [3:0]                 iomem_wstrb;
  logic [31:0]                iomem_addr;
  logic [31:0]                iomem_wdata;
  logic                       iomem_ready;
  logic [31:0]                iomem_rdata;

  logic [31:0]                wbm_adr_o;
  logic [31:0]                wbm_dat_o;
  logic                       wbm_we_o;
  logic [3:0]                 wbm_sel_o;
  logic [NUM_SLAVES-1:0]      wbm_cyc_o;
  logic [NUM_SLAVES-1:0]      wbm_stb_o;
  logic [NUM_SLAVES-1:0]      wbm_ack_i;
  logic [32*NUM_SLAVES-1:0]   wbm_dat_i;

  logic                       err_clr;
  logic                       err_o;
  logic [7:0]                 err_count;

  modport master (
    input  iomem_valid, iomem_wstrb, iomem_addr, iomem_wdata,
    input  wbm_ack_i, wbm_dat_i, err_clr,
    output iomem_ready, iomem_rdata,
    output wbm_adr_o, wbm_dat_o, wbm_we_o, wbm_sel_o, wbm_cyc_o, wbm_stb_o,
    output err_o, err_count
  );

  modport slave (
    output iomem_valid, iomem_wstrb, iomem_addr, iomem_wdata,
    output wbm_ack_i, wbm_dat_i, err_clr,
    input  iomem_ready, iomem_rdata,
    input  wbm_adr_o, wbm_dat_o, wbm_we_o, wbm_sel_o, wbm_cyc_o, wbm_stb_o,
    input  err_o, err_count
  );
endinterface

// File: rtl/iomem_wb_bridge.sv
// PicoSoC iomem to multi-slave Wishbone bridge.
// Decodes a slave index from the address, runs one Wishbone cycle per
// request, returns registered read data, and answers with an error word on
// decode errors or bus timeouts. Errors are kept in a sticky flag and a
// saturating counter.
module iomem_wb_bridge #(
  parameter int unsigned NUM_SLAVES     = 2,
  parameter logic [7:0]  WB_BASE        = 8'h03,
  parameter int unsigned SLAVE_SEL_LSB  = 16,
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter logic [31:0] ERR_RDATA      = 32'hDEADBEEF
) (
  input  logic              clk,
  input  logic              reset,
  iomem_wb_bridge_if.master bus
);

  localparam int unsigned    IDX_W   = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
  localparam logic [IDX_W:0] NS_LIM  = (IDX_W + 1)'(NUM_SLAVES);
  localparam logic [15:0]    TO_LAST = 16'(TIMEOUT_CYCLES - 1);
  localparam bit             TO_EN   = (TIMEOUT_CYCLES != 0);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_RESP   = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic [31:0]           adr_q, adr_d;
  logic [31:0]           dat_q, dat_d;
  logic                  we_q, we_d;
  logic [3:0]            sel_q, sel_d;
  logic [NUM_SLAVES-1:0] cyc_q, cyc_d;
  logic [15:0]           timer_q, timer_d;
  logic [31:0]           rdata_q, rdata_d;
  logic                  ready_q, ready_d;
  logic                  err_q, err_d;
  logic [7:0]            cnt_q, cnt_d;

  logic [IDX_W-1:0]      req_idx;
  logic                  in_range;
  logic                  idx_ok;
  logic                  ack_sel;
  logic [31:0]           ack_dat;
  logic                  err_ev;

  // Error counter stops at its maximum instead of wrapping.
  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  // One-hot cycle vector for a decoded slave index.
  function automatic logic [NUM_SLAVES-1:0] slave_onehot(input logic [IDX_W-1:0] idx);
    logic [NUM_SLAVES-1:0] v;
    v = '0;
    for (int k = 0; k < int'(NUM_SLAVES); k++) begin
      v[k] = (idx == IDX_W'(k));
    end
    return v;
  endfunction

  assign req_idx  = bus.iomem_addr[SLAVE_SEL_LSB +: IDX_W];
  assign in_range = (bus.iomem_addr[31:24] >= WB_BASE);
  assign idx_ok   = ({1'b0, req_idx} < NS_LIM);

  // The one-hot cyc vector masks out acks from slaves not in a cycle.
  assign ack_sel  = |(bus.wbm_ack_i & cyc_q);

  // Read-data mux driven by the one-hot cyc vector.
  always_comb begin
    ack_dat = '0;
    for (int k = 0; k < int'(NUM_SLAVES); k++) begin
      if (cyc_q[k]) ack_dat = ack_dat | bus.wbm_dat_i[32*k +: 32];
    end
  end

  // Transfer FSM: next state, bus latches, response and error events.
  always_comb begin
    state_d = state_q;
    adr_d   = adr_q;
    dat_d   = dat_q;
    we_d    = we_q;
    sel_d   = sel_q;
    cyc_d   = cyc_q;
    timer_d = timer_q;
    rdata_d = rdata_q;
    ready_d = 1'b0;
    err_ev  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.iomem_valid && in_range) begin
          if (idx_ok) begin
            adr_d   = bus.iomem_addr;
            dat_d   = bus.iomem_wdata;
            we_d    = |bus.iomem_wstrb;
            sel_d   = (|bus.iomem_wstrb) ? bus.iomem_wstrb : 4'hF;
            cyc_d   = slave_onehot(req_idx);
            timer_d = '0;
            state_d = ST_ACTIVE;
          end else begin
            // Index beyond the populated slaves: answer without a bus cycle.
            rdata_d = ERR_RDATA;
            ready_d = 1'b1;
            err_ev  = 1'b1;
            state_d = ST_RESP;
          end
        end
      end
      ST_ACTIVE: begin
        // A genuine ack beats a timeout landing on the same edge.
        if (ack_sel) begin
          rdata_d = ack_dat;
          ready_d = 1'b1;
          cyc_d   = '0;
          we_d    = 1'b0;
          state_d = ST_RESP;
        end else if (TO_EN && (timer_q == TO_LAST)) begin
          rdata_d = ERR_RDATA;
          ready_d = 1'b1;
          cyc_d   = '0;
          we_d    = 1'b0;
          err_ev  = 1'b1;
          state_d = ST_RESP;
        end else begin
          timer_d = timer_q + 16'd1;
        end
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Sticky error flag and counter; a new error outranks a clear on the same edge.
  always_comb begin
    err_d = err_q;
    cnt_d = cnt_q;
    if (err_ev) begin
      err_d = 1'b1;
      cnt_d = bus.err_clr ? 8'd1 : sat_inc(cnt_q);
    end else if (bus.err_clr) begin
      err_d = 1'b0;
      cnt_d = 8'd0;
    end
  end

  // State and output registers; reset aborts any transfer without a ready pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      adr_q   <= '0;
      dat_q   <= '0;
      we_q    <= 1'b0;
      sel_q   <= '0;
      cyc_q   <= '0;
      timer_q <= '0;
      rdata_q <= '0;
      ready_q <= 1'b0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      adr_q   <= adr_d;
      dat_q   <= dat_d;
      we_q    <= we_d;
      sel_q   <= sel_d;
      cyc_q   <= cyc_d;
      timer_q <= timer_d;
      rdata_q <= rdata_d;
      ready_q <= ready_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.iomem_ready = ready_q;
  assign bus.iomem_rdata = rdata_q;
  assign bus.wbm_adr_o   = adr_q;
  assign bus.wbm_dat_o   = dat_q;
  assign bus.wbm_we_o    = we_q;
  assign bus.wbm_sel_o   = sel_q;
  assign bus.wbm_cyc_o   = cyc_q;
  assign bus.wbm_stb_o   = cyc_q;
  assign bus.err_o       = err_q;
  assign bus.err_count   = cnt_q;

endmodule
